// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction fetch stage.
//   fetch_state_e  : fetch FSM states (FETCH, HOLD, ERROR)
//   FAULT_*        : fault_code encodings reported to the rest of the core
//   NOP_INTR       : default instruction presented after reset / on error
//   is_misaligned  : helper that flags a PC that is not word aligned
package fetch_pkg;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    ERROR = 2'd2
  } fetch_state_e;

  localparam logic [1:0] FAULT_NONE     = 2'b00;
  localparam logic [1:0] FAULT_MISALIGN = 2'b01;
  localparam logic [1:0] FAULT_TIMEOUT  = 2'b10;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  localparam int WAIT_CNT_W = 8;

  // A fetch address must have its two low bits clear.
  function automatic logic is_misaligned(input logic [31:0] addr);
    return (addr[1:0] != 2'b00);
  endfunction

endpackage

// File: rtl/fetch_timeout_counter.sv
// fetch_timeout_counter: counts cycles a memory request has waited.
//   clk      : system clock
//   reset    : synchronous active-high reset (count -> 0)
//   clear    : synchronous clear (request completed)
//   inc      : one more cycle spent waiting
//   expired  : the count has reached TIMEOUT_CYCLES-1, i.e. the current
//              waiting cycle is the TIMEOUT_CYCLES-th one
// The count saturates at its maximum instead of wrapping, so a stalled
// request can never alias back to a small count.
module fetch_timeout_counter
  import fetch_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic inc,
  output logic expired
);

  localparam logic [WAIT_CNT_W-1:0] LIMIT   = WAIT_CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [WAIT_CNT_W-1:0] CNT_MAX = {WAIT_CNT_W{1'b1}};

  logic [WAIT_CNT_W-1:0] count_r;

  // Saturating wait-cycle counter with clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_r <= {WAIT_CNT_W{1'b0}};
    end else if (clear) begin
      count_r <= {WAIT_CNT_W{1'b0}};
    end else if (inc && (count_r != CNT_MAX)) begin
      count_r <= count_r + WAIT_CNT_W'(1);
    end else begin
      count_r <= count_r;
    end
  end

  assign expired = (count_r == LIMIT);

endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: fetch stage between the PC logic and decode.
//   clk, reset    : clock and synchronous active-high reset
//   pc            : current PC from the PC logic
//   pc_enable     : one-cycle pulse, PC logic loads its next PC on this edge
//   imem_req      : instruction memory request (high only in FETCH)
//   imem_addr     : fetch address (mirrors pc)
//   imem_ready    : memory returns imem_rdata this cycle
//   imem_rdata    : instruction word from memory
//   decode_ready  : decode consumes the held instruction this cycle
//   instr         : registered instruction for decode
//   instr_pc      : PC the held instruction came from
//   instr_valid   : instr / instr_pc valid
//   fault         : sticky error flag
//   fault_code    : 00 none, 01 misaligned PC, 10 memory timeout
//   fetch_count   : instructions consumed by decode (wraps)
// Once a fault is taken the unit parks in ERROR until reset.
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter int          TIMEOUT_CYCLES = 16,
  parameter logic [31:0] RESET_INSTR    = NOP_INSTR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc,
  output logic        pc_enable,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  input  logic        decode_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        instr_valid,
  output logic        fault,
  output logic [1:0]  fault_code,
  output logic [31:0] fetch_count
);

  fetch_state_e state_r, state_s;

  logic [31:0] instr_r, instr_s;
  logic [31:0] instr_pc_r, instr_pc_s;
  logic        instr_valid_r, instr_valid_s;
  logic        fault_r, fault_s;
  logic [1:0]  fault_code_r, fault_code_s;
  logic [31:0] fetch_count_r, fetch_count_s;

  logic wait_clear_s;
  logic wait_inc_s;
  logic wait_expired_s;

  fetch_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (clk),
    .reset  (reset),
    .clear  (wait_clear_s),
    .inc    (wait_inc_s),
    .expired(wait_expired_s)
  );

  // Next-state and next-register logic for the fetch FSM.
  always_comb begin
    state_s       = state_r;
    instr_s       = instr_r;
    instr_pc_s    = instr_pc_r;
    instr_valid_s = instr_valid_r;
    fault_s       = fault_r;
    fault_code_s  = fault_code_r;
    fetch_count_s = fetch_count_r;
    wait_clear_s  = 1'b0;
    wait_inc_s    = 1'b0;

    case (state_r)
      FETCH: begin
        // Misalignment wins over a simultaneous imem_ready.
        if (is_misaligned(pc)) begin
          state_s       = ERROR;
          fault_s       = 1'b1;
          fault_code_s  = FAULT_MISALIGN;
          instr_s       = RESET_INSTR;
          instr_valid_s = 1'b0;
        end else if (imem_ready) begin
          state_s       = HOLD;
          instr_s       = imem_rdata;
          instr_pc_s    = pc;
          instr_valid_s = 1'b1;
          wait_clear_s  = 1'b1;
        end else begin
          wait_inc_s = 1'b1;
          // expired means this non-ready cycle is the last one allowed.
          if (wait_expired_s) begin
            state_s       = ERROR;
            fault_s       = 1'b1;
            fault_code_s  = FAULT_TIMEOUT;
            instr_s       = RESET_INSTR;
            instr_valid_s = 1'b0;
          end else begin
            state_s = FETCH;
          end
        end
      end
      HOLD: begin
        if (decode_ready) begin
          state_s       = FETCH;
          instr_valid_s = 1'b0;
          fetch_count_s = fetch_count_r + 32'd1;
        end else begin
          state_s = HOLD;
        end
      end
      ERROR: begin
        state_s       = ERROR;
        instr_s       = RESET_INSTR;
        instr_valid_s = 1'b0;
      end
      default: begin
        // Unreachable encoding: park safely and raise the fault flag.
        state_s       = ERROR;
        fault_s       = 1'b1;
        instr_s       = RESET_INSTR;
        instr_valid_s = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r       <= FETCH;
      instr_r       <= RESET_INSTR;
      instr_pc_r    <= 32'h0000_0000;
      instr_valid_r <= 1'b0;
      fault_r       <= 1'b0;
      fault_code_r  <= FAULT_NONE;
      fetch_count_r <= 32'h0000_0000;
    end else begin
      state_r       <= state_s;
      instr_r       <= instr_s;
      instr_pc_r    <= instr_pc_s;
      instr_valid_r <= instr_valid_s;
      fault_r       <= fault_s;
      fault_code_r  <= fault_code_s;
      fetch_count_r <= fetch_count_s;
    end
  end

  // Handshake outputs are decoded from state so the PC logic and memory
  // see them in the same cycle; both are forced low while reset is high.
  assign imem_req    = (state_r == FETCH) && !reset;
  assign pc_enable   = (state_r == HOLD) && decode_ready && !reset;
  assign imem_addr   = pc;

  assign instr       = instr_r;
  assign instr_pc    = instr_pc_r;
  assign instr_valid = instr_valid_r;
  assign fault       = fault_r;
  assign fault_code  = fault_code_r;
  assign fetch_count = fetch_count_r;

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Fetch stage directly downstream of the PC register/next-PC logic. Takes the current `pc`, issues a request to a variable-latency instruction memory, and holds the returned word for decode.
- Drives `pc_enable` back to the PC logic so the PC advances exactly once per instruction consumed by decode.
- Detects misaligned PCs and memory timeouts, and parks in a sticky error state.

Parameters:
- TIMEOUT_CYCLES, 16, max cycles `imem_req` may stay high without `imem_ready` before a bus error (legal range 1..255).
- RESET_INSTR, 32'h0000_0000, value of `instr` after reset and on error (NOP encoding).

Ports:
- clk  input  1  system clock; all state updates on posedge.
- reset  input  1  synchronous, active-high reset.
- pc  input  32  current PC from the PC logic.
- pc_enable  output  1  one-cycle pulse: PC logic loads its next-PC on this edge.
- imem_req  output  1  instruction memory request.
- imem_addr  output  32  word-aligned fetch address; equals `pc` while `imem_req`=1.
- imem_ready  input  1  memory returns `imem_rdata` this cycle; sampled only while `imem_req`=1.
- imem_rdata  input  32  instruction word.
- decode_ready  input  1  decode consumes the held instruction this cycle.
- instr  output  32  registered instruction for decode.
- instr_pc  output  32  PC the held instruction was fetched from.
- instr_valid  output  1  `instr`/`instr_pc` valid.
- fault  output  1  sticky error flag.
- fault_code  output  2  00 none, 01 misaligned PC, 10 memory timeout.
- fetch_count  output  32  number of instructions consumed; wraps modulo 2^32.

Behaviour:
- Reset (synchronous, any state, including mid-request): state=FETCH, `instr`=RESET_INSTR, `instr_pc`=0, `instr_valid`=0, `fault`=0, `fault_code`=00, `fetch_count`=0, wait counter=0. `imem_req`=0 and `pc_enable`=0 during the reset cycle.
- Outputs decoded from state: `imem_req`=1 iff state=FETCH and not reset. `pc_enable`=1 iff state=HOLD and `decode_ready`=1 (combinational). `imem_addr`=`pc` (combinational).
- FETCH:
  - If `pc[1:0]`!=0: `imem_req` still asserts this cycle (memory must ignore it). Next state ERROR, `fault_code`=01, `fault`=1.
  - Else if `imem_ready`: `instr`<=`imem_rdata`, `instr_pc`<=`pc`, `instr_valid`<=1, wait counter<=0, next state HOLD.
  - Else: wait counter++. If the counter reaches TIMEOUT_CYCLES-1 in a non-ready cycle, next state ERROR, `fault_code`=10. The error is therefore flagged on the TIMEOUT_CYCLES-th cycle of waiting.
  - Misalignment has priority over `imem_ready` in the same cycle.
- HOLD:
  - `instr_valid`=1, `imem_req`=0.
  - When `decode_ready`: `pc_enable`=1 this cycle, `instr_valid`<=0, `fetch_count`<=`fetch_count`+1, next state FETCH.
  - Otherwise hold all outputs stable indefinitely.
- ERROR:
  - `imem_req`=0, `pc_enable`=0, `instr_valid`=0, `instr`=RESET_INSTR.
  - Remain until reset; `fault`/`fault_code` hold.
- Timing:
  - Zero-wait memory (`imem_ready` in the first FETCH cycle) gives a minimum of 2 cycles per instruction.
  - Latency from `imem_ready` to `instr_valid`=1 is 1 cycle.
- Invariants:
  - `pc` only changes on the edge after `pc_enable`, which is only asserted in HOLD. Hence `imem_addr` is stable for the whole life of a request.
  - Exactly one `pc_enable` per consumed instruction; never two consecutive cycles.
  - `decode_ready` outside HOLD is ignored.
  - `imem_ready` with `imem_req`=0 is ignored.
- Widths: the wait counter is 8 bits and saturates rather than wrapping. `fetch_count` wraps from FFFF_FFFF to 0.

Decomposition:
- Shared package `fetch_pkg`:
  - state enum {FETCH, HOLD, ERROR}
  - fault_code constants FAULT_NONE / FAULT_MISALIGN / FAULT_TIMEOUT
  - NOP_INSTR constant
- Optional sub-module `fetch_timeout_counter`: load/clear, increment, expired output, parameterised by TIMEOUT_CYCLES. Everything else stays in one module.

Test Plan:
- Zero-wait memory, `decode_ready`=1 always, `pc` stepping 0,4,8 -> `imem_req` in cycles 1,3,5. `instr_valid` in cycles 2,4,6 with `instr_pc`=0,4,8. `pc_enable` pulses in cycles 2,4,6. `fetch_count`=3.
- `imem_ready` delayed 3 cycles at pc=0x40, rdata=0x2108_0001 -> `imem_addr` stable at 0x40 for 4 cycles; `instr`=0x2108_0001 and `instr_valid`=1 the following cycle; no `pc_enable` before then.
- Instruction held with `decode_ready`=0 for 5 cycles, then 1 -> `instr`/`instr_pc` unchanged for 5 cycles, `imem_req`=0 throughout; a single `pc_enable` pulse; `fetch_count` increments by exactly 1.
- pc=0x0000_0042 in FETCH -> `fault`=1 and `fault_code`=01 next cycle; thereafter `imem_req`=0 and `instr_valid`=0 until reset.
- TIMEOUT_CYCLES=4, `imem_ready` never asserted -> `imem_req` high 4 cycles, `fault_code`=10 on the following cycle. A late `imem_ready` after that is ignored.
- Reset asserted during the 2nd wait cycle -> next cycle state FETCH, all outputs at reset values, wait counter 0; a subsequent fetch completes normally with `fetch_count`=1.
